// File: rtl/bit_reverse_arbiter.sv
// Shared serial bit-reversal engine with round-robin arbitration.
// A word from one of N_REQ requesters is reversed one bit per clock and
// returned on a single valid/ready port, tagged with the requester index.
module bit_reverse_arbiter #(
   parameter  int N_BITS = 8,
   parameter  int N_REQ  = 4,
   localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*N_BITS-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [N_BITS-1:0]       out_data,
   output logic [ID_W-1:0]         out_id,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int CNT_W = $clog2(N_BITS);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [N_BITS-1:0]  src;
   logic [N_BITS-1:0]  res;
   logic [N_BITS-1:0]  res_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    gnt;
   logic [ID_W-1:0]    sel;
   logic [ID_W-1:0]    cand;
   logic [N_BITS-1:0]  sel_data;
   logic               found;
   logic               last;

   // Round-robin search starting at ptr, plus the matching word mux
   always_comb begin
      found    = 1'b0;
      sel      = '0;
      cand     = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = ID_W'((32'(ptr) + i) % N_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (sel == ID_W'(k)) begin
            sel_data = req_data[k*N_BITS +: N_BITS];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      out_valid = 1'b0;
      busy      = 1'b0;
      res_nxt   = {res[N_BITS-2:0], src[0]};
      last      = (cnt == CNT_W'(N_BITS - 1));
      case (state)
         IDLE: begin
            if (found) begin
               req_ready[sel] = !rst;
               state_nxt      = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture, serial shift, result latch, priority pointer update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src      <= '0;
         res      <= '0;
         cnt      <= '0;
         ptr      <= '0;
         gnt      <= '0;
         out_data <= '0;
         out_id   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  src <= sel_data;
                  res <= '0;
                  cnt <= '0;
                  gnt <= sel;
               end
            end
            SHIFT: begin
               res <= res_nxt;
               src <= src >> 1;
               cnt <= cnt + 1'b1;
               if (last) begin
                  out_data <= res_nxt;
                  out_id   <= gnt;
               end
            end
            DONE: begin
               if (out_ready) begin
                  ptr <= (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
